keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 216 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : 4x4 matrix keypad scanner with a row synchronizer, column
//               scan, and press/release debounce. Reports one key at a time
//               as an encoded nibble with a held level and a press strobe.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SETTLE_CYCLES  : cycles each column is driven before its rows are sampled
//                    (3..15)
//   DEBOUNCE_COUNT : consecutive matching samples to accept a press or a
//                    release (2..255)
// Ports
//   clk        in  1  rising-edge clock
//   reset      in  1  asynchronous active-high reset
//   row_in     in  4  keypad rows, active-low, asynchronous to clk
//   col_out    out 4  column drive, exactly one bit low (the active column)
//   key_code   out 4  {row[1:0], col[1:0]} of the accepted key
//   key_valid  out 1  high while a debounced key is held
//   key_strobe out 1  one-cycle pulse per accepted press
// ============================================================================
module keypad_scanner #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_COUNT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_strobe
);

  localparam int CNT_W = $clog2(DEBOUNCE_COUNT + 1);
  localparam int SET_W = 4;

  localparam logic [CNT_W-1:0] DEB_TARGET  = CNT_W'(DEBOUNCE_COUNT);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  // --------------------------------------------------------------------------
  // Row synchronizer. Idle rows read high, so the flops reset to all ones to
  // avoid a false press right after reset.
  // --------------------------------------------------------------------------
  logic [3:0] sync1_q;
  logic [3:0] rs_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 4'b1111;
      rs_q    <= 4'b1111;
    end else begin
      sync1_q <= row_in;
      rs_q    <= sync1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Scanner state
  // --------------------------------------------------------------------------
  state_e           state_q,      state_d;
  logic [1:0]       col_q,        col_d;
  logic [1:0]       row_q,        row_d;
  logic [SET_W-1:0] settle_q,     settle_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [3:0]       key_code_q,   key_code_d;
  logic             key_valid_q,  key_valid_d;
  logic             key_strobe_q, key_strobe_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_SCAN;
      col_q        <= 2'd0;
      row_q        <= 2'd0;
      settle_q     <= '0;
      cnt_q        <= '0;
      key_code_q   <= 4'h0;
      key_valid_q  <= 1'b0;
      key_strobe_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      settle_q     <= settle_d;
      cnt_q        <= cnt_d;
      key_code_q   <= key_code_d;
      key_valid_q  <= key_valid_d;
      key_strobe_q <= key_strobe_d;
    end
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  logic             w_any_low;
  logic [1:0]       w_low_idx;
  logic             w_row_high;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_any_low  = ~&rs_q;
  // Only the captured row is watched outside SCAN; other rows are ignored.
  assign w_row_high = rs_q[row_q];
  // Saturating increment: the counter never wraps back to zero.
  assign w_cnt_inc  = (cnt_q == DEB_TARGET) ? cnt_q : cnt_q + CNT_W'(1);

  // Lowest-index low row wins when several rows are down in one column.
  always_comb begin
    w_low_idx = 2'd0;
    if (!rs_q[0]) begin
      w_low_idx = 2'd0;
    end else if (!rs_q[1]) begin
      w_low_idx = 2'd1;
    end else if (!rs_q[2]) begin
      w_low_idx = 2'd2;
    end else if (!rs_q[3]) begin
      w_low_idx = 2'd3;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    settle_d     = settle_q;
    cnt_d        = cnt_q;
    key_code_d   = key_code_q;
    key_valid_d  = key_valid_q;
    key_strobe_d = 1'b0;

    unique case (state_q)
      ST_SCAN: begin
        if (settle_q == SETTLE_LAST) begin
          // Last settle cycle of this column: rows are now valid for it.
          settle_d = '0;
          if (w_any_low) begin
            row_d   = w_low_idx;
            cnt_d   = '0;
            state_d = ST_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end

      ST_DEBOUNCE: begin
        if (!w_row_high) begin
          cnt_d = w_cnt_inc;
          if (w_cnt_inc == DEB_TARGET) begin
            state_d      = ST_HELD;
            key_code_d   = {row_q, col_q};
            key_valid_d  = 1'b1;
            key_strobe_d = 1'b1;
          end
        end else begin
          // Bounce: abandon this key silently and move on.
          state_d  = ST_SCAN;
          col_d    = col_q + 2'd1;
          settle_d = '0;
          cnt_d    = '0;
        end
      end

      ST_HELD: begin
        if (w_row_high) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (w_row_high) begin
          cnt_d = w_cnt_inc;
          if (w_cnt_inc == DEB_TARGET) begin
            state_d     = ST_SCAN;
            key_valid_d = 1'b0;
            col_d       = col_q + 2'd1;
            settle_d    = '0;
            cnt_d       = '0;
          end
        end else begin
          // Release glitch: back to holding, no new strobe.
          state_d = ST_HELD;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_SCAN;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs. The column drive decodes straight from col_q so reset forces
  // 4'b1110 without waiting for a clock edge.
  // --------------------------------------------------------------------------
  assign col_out    = ~(4'b0001 << col_q);
  assign key_code   = key_code_q;
  assign key_valid  = key_valid_q;
  assign key_strobe = key_strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Scoreboard bench for keypad_scanner. Stimulus pushes the
//               expected key code for each press that must be reported; a
//               monitor pops and compares on every key_strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int SETTLE = 4;
  localparam int DEB    = 8;
  localparam int LAT_MAX = 4 * SETTLE + 2 + DEB;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_strobe;

  logic [15:0] pressed;        // bit r*4+c set when key (r,c) is closed
  logic [3:0]  exp_q[$];
  logic        prev_strobe = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  keypad_scanner #(
    .SETTLE_CYCLES (SETTLE),
    .DEBOUNCE_COUNT(DEB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_strobe(key_strobe)
  );

  always #5 clk = ~clk;

  // Keypad model: a closed key pulls its row low while its column is driven.
  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest expected code.
  always @(negedge clk) begin
    if (!reset && key_strobe) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_strobe: key_code=%0h, expected no strobe", key_code);
      end else begin
        check("strobe_code", key_code, exp_q.pop_front());
      end
      check("strobe_valid", key_valid, 1);
      check("strobe_width", prev_strobe, 0);
    end
    prev_strobe <= key_strobe;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_strobe(input int bound, output int lat);
    lat = 0;
    while (lat < bound) begin
      tick();
      lat++;
      if (key_strobe === 1'b1) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL strobe_timeout: no key_strobe within %0d cycles, expected one", bound);
  endtask

  task automatic hold_check(input int n, input logic [3:0] code);
    repeat (n) begin
      tick();
      check("held_valid", key_valid, 1);
      check("held_code", key_code, code);
    end
  endtask

  // Release a held key: valid must survive 2 sync + 1 detect + DEB-1 samples
  // and drop on the edge of the DEB-th consecutive high sample.
  task automatic release_check(input int r, input int c, input logic [3:0] code);
    pressed[r*4+c] = 1'b0;
    for (int i = 1; i <= DEB + 3; i++) begin
      tick();
      if (i == DEB + 2) check("rel_valid_hold", key_valid, 1);
      if (i == DEB + 3) check("rel_valid_drop", key_valid, 0);
    end
    check("rel_code_kept", key_code, code);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    pressed = 16'h0;
    reset   = 1'b1;
    #1;
    // Reset state
    check("rst_col", col_out, 4'b1110);
    check("rst_code", key_code, 0);
    check("rst_valid", key_valid, 0);
    check("rst_strobe", key_strobe, 0);

    // Idle scan: 4 cycles per column, wrapping
    @(negedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      logic [3:0] exp_col;
      exp_col = ~(4'b0001 << ((k / SETTLE) % 4));
      check("idle_col", col_out, exp_col);
      check("idle_outs", {key_valid, key_strobe}, 0);
      tick();
    end

    // Single press (2,1), latency bounded, held 100 cycles, then release
    exp_q.push_back(4'h9);
    pressed[2*4+1] = 1'b1;
    wait_strobe(60, lat);
    check("lat_max", (lat <= LAT_MAX), 1);
    check("lat_min", (lat >= DEB + 2), 1);
    hold_check(100 - lat, 4'h9);
    release_check(2, 1, 4'h9);
    repeat (10) tick();

    // Bouncing press (1,3): 5 low / 1 high, then stable
    repeat (6) begin
      pressed[1*4+3] = 1'b1;
      repeat (5) tick();
      pressed[1*4+3] = 1'b0;
      tick();
    end
    check("bounce_valid", key_valid, 0);
    exp_q.push_back(4'h7);
    pressed[1*4+3] = 1'b1;
    wait_strobe(60, lat);
    hold_check(20, 4'h7);
    release_check(1, 3, 4'h7);
    repeat (10) tick();

    // Two keys in one column: lowest row wins, the other waits
    exp_q.push_back(4'h2);
    pressed[0*4+2] = 1'b1;
    pressed[3*4+2] = 1'b1;
    wait_strobe(60, lat);
    hold_check(40, 4'h2);
    exp_q.push_back(4'hE);
    release_check(0, 2, 4'h2);
    wait_strobe(60, lat);
    hold_check(10, 4'hE);
    release_check(3, 2, 4'hE);
    repeat (10) tick();

    // Short release glitch during hold
    exp_q.push_back(4'h0);
    pressed[0] = 1'b1;
    wait_strobe(60, lat);
    hold_check(5, 4'h0);
    pressed[0] = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (i == 4) pressed[0] = 1'b1;
      check("glitch_valid", key_valid, 1);
    end
    release_check(0, 0, 4'h0);
    repeat (10) tick();

    // Reset during HELD, key stays down
    exp_q.push_back(4'hF);
    pressed[3*4+3] = 1'b1;
    wait_strobe(60, lat);
    hold_check(10, 4'hF);
    reset = 1'b1;
    #1;
    check("async_valid", key_valid, 0);
    check("async_col", col_out, 4'b1110);
    check("async_strobe", key_strobe, 0);
    check("async_code", key_code, 0);
    exp_q.push_back(4'hF);
    #1;
    reset = 1'b0;
    wait_strobe(60, lat);
    hold_check(10, 4'hF);
    release_check(3, 3, 4'hF);
    repeat (5) tick();

    check("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
